// File: rtl/seg_pkg.sv
// Shared definitions for the scrolling seven-segment pattern source.
// Latency: none (constants and types only).
// Backpressure: none; the display driver consumes SEG_DATA every cycle.
package seg_pkg;

  // Character codes above the hex range
  localparam logic [4:0] CH_BLANK = 5'h10;
  localparam logic [4:0] CH_H     = 5'h11;
  localparam logic [4:0] CH_E     = 5'h12;
  localparam logic [4:0] CH_L     = 5'h13;
  localparam logic [4:0] CH_O     = 5'h14;
  localparam logic [4:0] CH_P     = 5'h15;
  localparam logic [4:0] CH_DASH  = 5'h16;
  localparam logic [4:0] CH_DOT   = 5'h17;

  // Segment byte order: upper, right upper, right lower, lower,
  // left lower, left upper, center, dot (MSB first)
  localparam logic [7:0] SEG_BLANK = 8'b00000000;
  localparam logic [7:0] SEG_0     = 8'b11111100;
  localparam logic [7:0] SEG_1     = 8'b01100000;
  localparam logic [7:0] SEG_H     = 8'b01101110;
  localparam logic [7:0] SEG_E     = 8'b10011110;
  localparam logic [7:0] SEG_L     = 8'b00011100;
  localparam logic [7:0] SEG_O     = 8'b11111100;
  localparam logic [7:0] SEG_P     = 8'b11001110;
  localparam logic [7:0] SEG_DOT   = 8'b00000001;
  localparam logic [7:0] SEG_DASH  = 8'b00000010;

  // Number of digits in the visible window
  localparam int DIGITS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/seg_char_decode.sv
// Maps one 5-bit character code to its 8-bit segment pattern.
// Latency: combinational.
// Backpressure: none.
module seg_char_decode
  import seg_pkg::*;
(
  input  logic [4:0] code_i,
  output logic [7:0] seg_o
);

  // Lookup: hex digits, a few letters and symbols, everything else blank
  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      5'h00:    seg_o = SEG_0;
      5'h01:    seg_o = SEG_1;
      5'h02:    seg_o = 8'b11011010;
      5'h03:    seg_o = 8'b11110010;
      5'h04:    seg_o = 8'b01100110;
      5'h05:    seg_o = 8'b10110110;
      5'h06:    seg_o = 8'b10111110;
      5'h07:    seg_o = 8'b11100000;
      5'h08:    seg_o = 8'b11111110;
      5'h09:    seg_o = 8'b11110110;
      5'h0A:    seg_o = 8'b11101110;
      5'h0B:    seg_o = 8'b00111110;
      5'h0C:    seg_o = 8'b10011100;
      5'h0D:    seg_o = 8'b01111010;
      5'h0E:    seg_o = 8'b10011110;
      5'h0F:    seg_o = 8'b10001110;
      CH_H:     seg_o = SEG_H;
      CH_E:     seg_o = SEG_E;
      CH_L:     seg_o = SEG_L;
      CH_O:     seg_o = SEG_O;
      CH_P:     seg_o = SEG_P;
      CH_DASH:  seg_o = SEG_DASH;
      CH_DOT:   seg_o = SEG_DOT;
      default:  seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scroll_source.sv
// Message buffer plus 8-character scrolling window feeding the 7-seg driver.
// Latency: SEG_DATA/FRAME follow a position change by one cycle; writes show one cycle after the write edge.
// Backpressure: none; PAUSE freezes the window, the driver samples every cycle.
module seg_scroll_source
  import seg_pkg::*;
#(
  parameter int MSG_DEPTH  = 16,
  parameter int AW         = 4,
  parameter int SCROLL_DIV = 12000000
) (
  input  logic          CLK,
  input  logic          N_RST,
  input  logic          WR_EN,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [4:0]    WR_CHAR,
  input  logic [AW:0]   MSG_LEN,
  input  logic          START,
  input  logic          STOP,
  input  logic          PAUSE,
  output logic [63:0]   SEG_DATA,
  output logic          FRAME,
  output logic          RUNNING
);

  localparam int            PW         = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCROLL_DIV - 1);
  localparam logic [AW:0]   LEN_MIN    = (AW+1)'(DIGITS);
  localparam logic [AW:0]   LEN_MAX    = (AW+1)'(MSG_DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] pos_q, pos_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [AW:0]   len_q, len_d;
  logic          load_q, load_d;
  logic [4:0]    msg_q [MSG_DEPTH];
  logic [63:0]   seg_q, seg_d;
  logic          frame_q, frame_d;
  logic [AW:0]   len_in;
  logic [4:0]    win_chr [DIGITS];
  logic [7:0]    win_seg [DIGITS];
  logic [63:0]   win_pat;

  // Clamp the requested length to the window width and buffer depth
  always_comb begin
    len_in = MSG_LEN;
    if (MSG_LEN < LEN_MIN) len_in = LEN_MIN;
    else if (MSG_LEN > LEN_MAX) len_in = LEN_MAX;
  end

  // Control FSM: start/restart, stop (wins over start), prescaled scroll steps
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    presc_d = presc_q;
    len_d   = len_q;
    load_d  = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (START && !STOP) begin
          state_d = RUN;
          pos_d   = '0;
          len_d   = len_in;
          load_d  = 1'b1;
        end
      end
      RUN: begin
        if (STOP) begin
          state_d = IDLE;
          presc_d = '0;
        end else if (START) begin
          pos_d   = '0;
          presc_d = '0;
          len_d   = len_in;
          load_d  = 1'b1;
        end else if (!PAUSE) begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            pos_d   = ({1'b0, pos_q} == len_q - 1'b1) ? '0 : pos_q + AW'(1);
            load_d  = 1'b1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window addressing: pos < len and len >= 8, so one conditional subtract wraps
  always_comb begin
    logic [AW:0] idx;
    for (int i = 0; i < DIGITS; i++) begin
      idx = {1'b0, pos_q} + (AW+1)'(i);
      if (idx >= len_q) idx = idx - len_q;
      win_chr[i] = msg_q[idx[AW-1:0]];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg_char_decode u_dec (
      .code_i (win_chr[g]),
      .seg_o  (win_seg[g])
    );
  end

  // Pack digits, digit 0 in the top byte; blank outside RUN or when stopping
  always_comb begin
    win_pat = '0;
    for (int i = 0; i < DIGITS; i++) win_pat[63-8*i -: 8] = win_seg[i];
    seg_d   = (state_q == RUN && !STOP) ? win_pat : '0;
    frame_d = load_q && (state_q == RUN) && !STOP;
  end

  // Control state registers
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_q <= IDLE;
      pos_q   <= '0;
      presc_q <= '0;
      len_q   <= LEN_MIN;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
      len_q   <= len_d;
      load_q  <= load_d;
    end
  end

  // Message buffer: host writes accepted in any state
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      for (int i = 0; i < MSG_DEPTH; i++) msg_q[i] <= CH_BLANK;
    end else if (WR_EN) begin
      msg_q[WR_ADDR] <= WR_CHAR;
    end
  end

  // Output registers: pattern refreshed every cycle, frame strobe on new window
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      seg_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_d;
      frame_q <= frame_d;
    end
  end

  assign SEG_DATA = seg_q;
  assign FRAME    = frame_q;
  assign RUNNING  = (state_q == RUN);

endmodule

// File: tb/tb_seg_scroll_source.sv
// Self-checking bench for seg_scroll_source: decode table vectors, scroll/clamp/pause/collision
// sequences, and randomized traffic against a behavioural model (modulo arithmetic on an array).
// Inputs change 1ns after the rising edge; outputs are compared at that same point.
module tb_seg_scroll_source;

  localparam int DIV = 4;
  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        N_RST;
  logic        WR_EN;
  logic [3:0]  WR_ADDR;
  logic [4:0]  WR_CHAR;
  logic [4:0]  MSG_LEN;
  logic        START;
  logic        STOP;
  logic        PAUSE;
  logic [63:0] SEG_DATA;
  logic        FRAME;
  logic        RUNNING;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  int m_buf [DEPTH];
  bit m_run;
  int m_pos, m_presc, m_len;
  bit m_pend;

  seg_scroll_source #(.MSG_DEPTH(DEPTH), .AW(4), .SCROLL_DIV(DIV)) dut (
    .CLK(CLK), .N_RST(N_RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_CHAR(WR_CHAR),
    .MSG_LEN(MSG_LEN), .START(START), .STOP(STOP), .PAUSE(PAUSE),
    .SEG_DATA(SEG_DATA), .FRAME(FRAME), .RUNNING(RUNNING)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] ref_dec(input int c);
    case (c)
      0: return 8'hFC;  1: return 8'h60;  2: return 8'hDA;  3: return 8'hF2;
      4: return 8'h66;  5: return 8'hB6;  6: return 8'hBE;  7: return 8'hE0;
      8: return 8'hFE;  9: return 8'hF6; 10: return 8'hEE; 11: return 8'h3E;
      12: return 8'h9C; 13: return 8'h7A; 14: return 8'h9E; 15: return 8'h8E;
      17: return 8'h6E; 18: return 8'h9E; 19: return 8'h1C; 20: return 8'hFC;
      21: return 8'hCE; 22: return 8'h02; 23: return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_buf[i] = 16;
    m_run = 0; m_pos = 0; m_presc = 0; m_len = 8; m_pend = 0;
  endtask

  task automatic model_restart();
    int l;
    l = int'(MSG_LEN);
    if (l < 8) l = 8;
    if (l > DEPTH) l = DEPTH;
    m_len = l; m_pos = 0; m_presc = 0; m_pend = 1;
  endtask

  // One clock: predict, advance the model, clock the DUT, compare, clear pulses
  task automatic cycle();
    logic [63:0] es;
    logic ef;
    es = '0;
    if (m_run && !STOP)
      for (int i = 0; i < 8; i++) es[63-8*i -: 8] = ref_dec(m_buf[(m_pos + i) % m_len]);
    ef = m_pend && m_run && !STOP;
    m_pend = 0;
    if (m_run) begin
      if (STOP) begin
        m_run = 0; m_presc = 0;
      end else if (START) begin
        model_restart();
      end else if (!PAUSE) begin
        m_presc++;
        if (m_presc == DIV) begin
          m_presc = 0;
          m_pos = (m_pos + 1) % m_len;
          m_pend = 1;
        end
      end
    end else if (START && !STOP) begin
      m_run = 1;
      model_restart();
    end
    if (WR_EN) m_buf[WR_ADDR] = int'(WR_CHAR);
    @(posedge CLK); #1;
    chk("seg_data", SEG_DATA, es);
    chk("frame", {63'b0, FRAME}, {63'b0, ef});
    chk("running", {63'b0, RUNNING}, {63'b0, m_run});
    START = 0; STOP = 0; WR_EN = 0;
  endtask

  task automatic wr(input int addr, input int ch);
    WR_EN = 1; WR_ADDR = 4'(addr); WR_CHAR = 5'(ch);
    cycle();
  endtask

  task automatic start_msg(input int len);
    MSG_LEN = 5'(len); START = 1;
    cycle();
  endtask

  task automatic async_reset();
    N_RST = 0;
    #2;
    chk("rst_seg", SEG_DATA, 64'h0);
    chk("rst_frame", {63'b0, FRAME}, 64'h0);
    chk("rst_running", {63'b0, RUNNING}, 64'h0);
    model_reset();
    @(posedge CLK); #1;
    N_RST = 1;
  endtask

  typedef struct {
    logic [39:0] chars;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [4];
  int frames;

  initial begin
    tbl[0] = '{chars: {5'h11, 5'h12, 5'h13, 5'h13, 5'h14, 5'h10, 5'h10, 5'h10}, exp: 64'h6E9E1C1CFC000000};
    tbl[1] = '{chars: {5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07}, exp: 64'hFC60DAF266B6BEE0};
    tbl[2] = '{chars: {5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F}, exp: 64'hFEF6EE3E9C7A9E8E};
    tbl[3] = '{chars: {5'h15, 5'h16, 5'h17, 5'h18, 5'h1F, 5'h10, 5'h01, 5'h00}, exp: 64'hCE020100000060FC};

    N_RST = 0; WR_EN = 0; WR_ADDR = 0; WR_CHAR = 0; MSG_LEN = 8;
    START = 0; STOP = 0; PAUSE = 0;
    #2;
    chk("init_seg", SEG_DATA, 64'h0);
    chk("init_running", {63'b0, RUNNING}, 64'h0);
    model_reset();
    @(posedge CLK); #1;
    N_RST = 1;
    cycle();

    // Decode table vectors through a full 8-entry message
    for (int v = 0; v < 4; v++) begin
      STOP = 1; cycle();
      for (int j = 0; j < 8; j++) wr(j, int'(tbl[v].chars[39-5*j -: 5]));
      start_msg(8);
      cycle();
      chk("tbl_seg", SEG_DATA, tbl[v].exp);
      chk("tbl_frame", {63'b0, FRAME}, 64'h1);
    end

    // Scroll and wrap with HELLO
    STOP = 1; cycle();
    for (int j = 0; j < 8; j++) wr(j, int'(tbl[0].chars[39-5*j -: 5]));
    start_msg(8);
    frames = 0;
    for (int k = 1; k <= 33; k++) begin
      cycle();
      if (k >= 2 && FRAME) frames++;
      if (k == 5) chk("scroll_step1", SEG_DATA, 64'h9E1C1CFC0000006E);
    end
    chk("scroll_wrap", SEG_DATA, 64'h6E9E1C1CFC000000);
    chk("scroll_frames", 64'(frames), 64'd8);

    // Length clamp: short length -> 8, long length -> depth
    for (int j = 0; j < 16; j++) wr(j, j);
    start_msg(3);
    for (int k = 1; k <= 33; k++) begin
      cycle();
      if (k == 29) chk("clamp8_step7", SEG_DATA, 64'hE0FC60DAF266B6BE);
    end
    chk("clamp8_wrap", SEG_DATA, 64'hFC60DAF266B6BEE0);
    start_msg(20);
    for (int k = 1; k <= 65; k++) begin
      cycle();
      if (k == 33) chk("clamp16_step8", SEG_DATA, 64'hFEF6EE3E9C7A9E8E);
      if (k == 61) chk("clamp16_step15", SEG_DATA, 64'h8EFC60DAF266B6BE);
    end
    chk("clamp16_wrap", SEG_DATA, 64'hFC60DAF266B6BEE0);

    // Pause holds the window; live writes still show, without FRAME
    PAUSE = 1;
    frames = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (FRAME) frames++;
    end
    chk("pause_frames", 64'(frames), 64'd0);
    chk("pause_seg", SEG_DATA, 64'hFC60DAF266B6BEE0);
    wr(m_pos, 23);
    cycle();
    chk("live_dot", {56'b0, SEG_DATA[63:56]}, 64'h01);
    wr(m_pos, 1);
    cycle();
    chk("live_one", {56'b0, SEG_DATA[63:56]}, 64'h60);
    chk("live_noframe", {63'b0, FRAME}, 64'h0);
    PAUSE = 0;

    // START and STOP together: stop wins
    START = 1; STOP = 1; cycle();
    chk("coll_running", {63'b0, RUNNING}, 64'h0);
    chk("coll_seg", SEG_DATA, 64'h0);

    // Restart while running
    start_msg(8);
    for (int k = 0; k < 10; k++) cycle();
    START = 1; cycle();
    cycle();
    chk("restart_seg", SEG_DATA, 64'h6060DAF266B6BEE0);
    chk("restart_frame", {63'b0, FRAME}, 64'h1);
    for (int k = 0; k < 4; k++) cycle();
    chk("restart_step", SEG_DATA, 64'h60DAF266B6BEE060);
    chk("restart_step_frame", {63'b0, FRAME}, 64'h1);

    // Reset mid-run, then start over a blank buffer
    async_reset();
    start_msg(0);
    cycle();
    chk("blank_seg", SEG_DATA, 64'h0);
    chk("blank_frame", {63'b0, FRAME}, 64'h1);
    cycle();

    // Randomized traffic against the model
    for (int k = 0; k < 2500; k++) begin
      if (k == 1200) async_reset();
      WR_EN = ($urandom % 4) == 0;
      WR_ADDR = 4'($urandom);
      WR_CHAR = 5'($urandom);
      MSG_LEN = 5'($urandom);
      START = ($urandom % 40) == 0;
      STOP = ($urandom % 80) == 0;
      if (($urandom % 20) == 0) PAUSE = ~PAUSE;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scroll_source.md
Name: seg_scroll_source

Overview:
- Upstream pattern source for the 8-digit seven-segment display driver.
- Holds a message of character codes written by the host.
- Scrolls an 8-character window across the message at a fixed tick rate.
- Presents the 64-bit segment pattern the driver consumes, plus a 1-cycle FRAME strobe on each new window.

Parameters:
- MSG_DEPTH, 16: message buffer entries; power of 2, at least 8.
- AW, 4: address width, log2(MSG_DEPTH).
- SCROLL_DIV, 12000000: CLK cycles per scroll step; at least 2.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- N_RST  in  1  asynchronous, active-low reset.
- WR_EN  in  1  write strobe for the message buffer.
- WR_ADDR  in  AW  buffer entry to write.
- WR_CHAR  in  5  character code to write.
- MSG_LEN  in  AW+1  message length, sampled on START.
- START  in  1  pulse: latch length, begin or restart scrolling.
- STOP  in  1  pulse: return to IDLE.
- PAUSE  in  1  level: hold the current window.
- SEG_DATA  out  64  segment pattern; digit i at bits [63-8i:56-8i], digit 0 leftmost. Per-byte bit order: upper, right upper, right lower, lower, left lower, left upper, center, dot.
- FRAME  out  1  1-cycle pulse when a new window appears on SEG_DATA.
- RUNNING  out  1  high in RUN state.

Behaviour:
- Reset (async, N_RST=0):
  - state IDLE; pos=0; prescaler=0; len=8.
  - all buffer entries = 0x10 (blank).
  - SEG_DATA=64'h0, FRAME=0, RUNNING=0.
- Buffer writes:
  - Accepted in any state; take effect at the edge where WR_EN=1.
  - SEG_DATA is re-registered every cycle in RUN, so a write to a displayed entry shows on SEG_DATA one cycle after the write edge.
  - A write never raises FRAME.
- States:
  - IDLE: SEG_DATA=0, prescaler held at 0.
    - START=1 -> RUN, pos=0, prescaler=0, len=clamp(MSG_LEN).
  - RUN: RUNNING=1.
    - STOP=1 -> IDLE; SEG_DATA=0 from the next edge.
    - START=1 (no STOP) -> restart: pos=0, prescaler=0, len re-latched.
- Simultaneous START and STOP: STOP wins.
- Length clamp:
  - MSG_LEN < 8 -> len=8.
  - MSG_LEN > MSG_DEPTH -> len=MSG_DEPTH.
- Prescaler (RUN only):
  - Counts 0..SCROLL_DIV-1 while PAUSE=0; holds while PAUSE=1.
  - Terminal count: prescaler -> 0 and pos -> (pos==len-1) ? 0 : pos+1.
- Window:
  - Digit i shows decode(buf[(pos+i) mod len]), i=0..7.
  - Since pos < len and len >= 8, the modulo is a single conditional subtract of len.
- Latency:
  - SEG_DATA reflects the current pos one cycle after pos changes.
  - FRAME=1 in the same cycle the new window first appears: one cycle after START, and one cycle after each scroll step.
  - PAUSE does not affect FRAME except by stopping steps.
- Character decode:
  - 0x00-0x0F: hex digits 0-F.
  - 0x10: blank (8'h00).
  - 0x11 H, 0x12 E, 0x13 L, 0x14 O, 0x15 P, 0x16 dash, 0x17 dot only.
  - 0x18-0x1F: blank.
  - Dot bit is 0 except for code 0x17.
- Reset mid-operation: immediate return to the reset values above, including buffer contents.

Decomposition:
- Shared package seg_pkg:
  - Character code constants: CH_BLANK=0x10, CH_H=0x11, CH_E=0x12, CH_L=0x13, CH_O=0x14, CH_P=0x15, CH_DASH=0x16, CH_DOT=0x17.
  - Segment constants: SEG_0=8'b11111100, SEG_1=8'b01100000, SEG_H=8'b01101110, SEG_E=8'b10011110, SEG_L=8'b00011100, SEG_O=8'b11111100, SEG_DOT=8'b00000001, SEG_DASH=8'b00000010.
  - State encoding: IDLE, RUN.
- One sub-module: seg_char_decode, combinational 5-bit code -> 8-bit pattern, instantiated 8 times.

Test Plan:
- Reset: assert N_RST=0 mid-run -> SEG_DATA=64'h0, FRAME=0, RUNNING=0 immediately; after release, START with buffer untouched -> SEG_DATA=64'h0 (all blank), FRAME pulses once.
- Basic message: write H,E,L,L,O,blank,blank,blank to addr 0-7; MSG_LEN=8; START -> next cycle SEG_DATA=64'h6E9E1C1CFC000000, FRAME=1 for one cycle.
- Scroll and wrap: SCROLL_DIV=4, same message -> step every 4 cycles; first step SEG_DATA=64'h9E1C1CFC0000006E; after 8 steps pattern returns to 64'h6E9E1C1CFC000000; 8 FRAME pulses.
- Length clamp and depth: MSG_LEN=3 -> wraps after 8 steps; MSG_LEN=20 with MSG_DEPTH=16 -> wraps after 16 steps, address 15 followed by 0.
- PAUSE and live write: PAUSE=1 for 20 cycles -> no FRAME, SEG_DATA unchanged. While paused, write 0x01 to displayed digit 0's entry -> SEG_DATA[63:56]=8'h60 one cycle after the write, FRAME stays 0.
- Control collisions: START and STOP in the same cycle during RUN -> IDLE, SEG_DATA=0 next cycle. START during RUN -> pos=0 window restored, FRAME pulse, prescaler restarted.
